// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-stage front end and its store buffer.
// sb_entry_t is sized by the default widths and is used by code working at those widths.
package mem_stage_pkg;

  localparam int DEF_DW       = 16;
  localparam int DEF_AW       = 16;
  localparam int DEF_SB_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    ST_WAIT,
    LD_WAIT
  } state_t;

  typedef struct packed {
    logic [DEF_AW-1:0] addr;
    logic [DEF_DW-1:0] data;
  } sb_entry_t;

endpackage

// File: rtl/mem_stage_sb_store_buffer.sv
// In-order circular store buffer with a parallel address lookup.
// On a lookup hit, hit_data returns the data of the youngest matching entry.
module store_buffer #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int SB_DEPTH = 4,
  parameter int PTR_W    = $clog2(SB_DEPTH)
) (
  input  logic                clk,
  input  logic                srst,
  input  logic                push,
  input  logic                pop,
  input  logic [AW-1:0]       push_addr,
  input  logic [DW-1:0]       push_data,
  input  logic [AW-1:0]       lookup_addr,
  output logic                full,
  output logic [PTR_W:0]      count,
  output logic [AW-1:0]       head_addr,
  output logic [DW-1:0]       head_data,
  output logic [SB_DEPTH-1:0] match,
  output logic [DW-1:0]       hit_data
);

  logic [AW-1:0]    addr_mem [SB_DEPTH];
  logic [DW-1:0]    data_mem [SB_DEPTH];
  logic [PTR_W-1:0] head_reg;
  logic [PTR_W-1:0] tail_reg;
  logic [PTR_W:0]   count_reg;

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[tail_reg] <= push_addr;
      data_mem[tail_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full      = (count_reg == (PTR_W+1)'(SB_DEPTH));
  assign count     = count_reg;
  assign head_addr = addr_mem[head_reg];
  assign head_data = data_mem[head_reg];

  // A slot is live when its distance from head is below count.
  generate
    for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] offset;
      assign offset    = PTR_W'(gi) - head_reg;
      assign match[gi] = ({1'b0, offset} < count_reg) && (addr_mem[gi] == lookup_addr);
    end
  endgenerate

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [PTR_W-1:0] idx;
    hit_data = '0;
    idx      = head_reg;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = head_reg + PTR_W'(k);
      if (match[idx]) hit_data = data_mem[idx];
    end
  end

endmodule

// File: rtl/mem_stage_sb.sv
// Memory-stage front end: posts stores into a store buffer, forwards loads that hit
// it, and sequences one outstanding memory op at a time (load misses before drains).
module mem_stage_sb
  import mem_stage_pkg::*;
#(
  parameter int DW       = DEF_DW,
  parameter int AW       = DEF_AW,
  parameter int SB_DEPTH = DEF_SB_DEPTH,
  parameter int PTR_W    = $clog2(SB_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          stall,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic [AW-1:0] addr_out,
  output logic          sb_empty,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_done,
  input  logic          mem_err
);

  state_t state_reg, state_next;
  logic [DW-1:0] rd_data_reg;
  logic          rd_valid_reg;
  logic          err_reg;

  logic                conflict, load_req, store_req, load_hit, load_miss;
  logic                sb_push, sb_pop, sb_full, sb_hit, ld_done;
  logic [PTR_W:0]      sb_count;
  logic [AW-1:0]       head_addr;
  logic [DW-1:0]       head_data, hit_data;
  logic [SB_DEPTH-1:0] sb_match;

  store_buffer #(.DW(DW), .AW(AW), .SB_DEPTH(SB_DEPTH), .PTR_W(PTR_W)) u_sb (
    .clk        (clk),
    .srst       (rst),
    .push       (sb_push),
    .pop        (sb_pop),
    .push_addr  (req_addr),
    .push_data  (req_wdata),
    .lookup_addr(req_addr),
    .full       (sb_full),
    .count      (sb_count),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .match      (sb_match),
    .hit_data   (hit_data)
  );

  assign conflict  = req_rd && req_wr;
  assign load_req  = req_rd && !req_wr;
  assign store_req = req_wr && !req_rd;
  assign sb_hit    = |sb_match;
  assign load_hit  = load_req && sb_hit;
  assign load_miss = load_req && !sb_hit;

  always_comb begin
    state_next = state_reg;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = head_addr;
    mem_wdata  = head_data;
    sb_pop     = 1'b0;
    ld_done    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load_miss) begin
          mem_rd     = 1'b1;
          mem_addr   = req_addr;
          state_next = LD_WAIT;
        end else if (sb_count != '0) begin
          mem_wr     = 1'b1;
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_wr = 1'b1;
        if (mem_done) begin
          sb_pop     = 1'b1;
          state_next = IDLE;
        end
      end
      LD_WAIT: begin
        mem_rd   = 1'b1;
        mem_addr = req_addr;
        if (mem_done) begin
          ld_done    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A full buffer still takes a store when the head retires in the same cycle.
  assign sb_push = store_req && (!sb_full || sb_pop);
  assign stall   = (store_req && !sb_push) || (load_miss && !ld_done);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rd_valid_reg <= ld_done || load_hit;
      if (ld_done)       rd_data_reg <= mem_rdata;
      else if (load_hit) rd_data_reg <= hit_data;
      if (conflict || mem_err) err_reg <= 1'b1;
    end
  end

  assign rd_data  = rd_data_reg;
  assign rd_valid = rd_valid_reg;
  assign err      = err_reg;
  assign addr_out = req_addr;
  assign sb_empty = (sb_count == '0) && (state_reg == IDLE);

endmodule

// File: tb/tb_mem_stage_sb.sv
// Self-checking bench for mem_stage_sb: scoreboard queues for memory writes and load
// results, plus per-scenario tasks with inline comparisons.
module tb_mem_stage_sb;
  import mem_stage_pkg::*;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_rd, req_wr;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          stall;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW-1:0] addr_out;
  logic          sb_empty, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rd, mem_wr;
  logic [DW-1:0] mem_rdata;
  logic          mem_done, mem_err;

  int cmp_cnt = 0;
  int mis_cnt = 0;

  sb_entry_t     wq[$];
  logic [DW-1:0] rq[$];

  always #5 clk = ~clk;

  mem_stage_sb #(.DW(DW), .AW(AW), .SB_DEPTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .stall    (stall),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .addr_out (addr_out),
    .sb_empty (sb_empty),
    .err      (err),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_rdata(mem_rdata),
    .mem_done (mem_done),
    .mem_err  (mem_err)
  );

  // Scoreboard: completed memory writes and load results, sampled mid-cycle.
  always @(negedge clk) begin : mon
    sb_entry_t     e;
    logic [DW-1:0] r;
    if (mem_wr && mem_done) begin
      cmp_cnt++;
      if (wq.size() == 0) begin
        mis_cnt++;
        $display("FAIL mem_write: unexpected write addr=%h data=%h, none queued", mem_addr, mem_wdata);
      end else begin
        e = wq.pop_front();
        if ({mem_addr, mem_wdata} !== {e.addr, e.data}) begin
          mis_cnt++;
          $display("FAIL mem_write: got addr=%h data=%h, required addr=%h data=%h", mem_addr, mem_wdata, e.addr, e.data);
        end else $display("write   addr=%h data=%h", mem_addr, mem_wdata);
      end
    end
    if (rd_valid) begin
      cmp_cnt++;
      if (rq.size() == 0) begin
        mis_cnt++;
        $display("FAIL rd_result: unexpected rd_valid data=%h", rd_data);
      end else begin
        r = rq.pop_front();
        if (rd_data !== r) begin
          mis_cnt++;
          $display("FAIL rd_result: got %h, required %h", rd_data, r);
        end else $display("load    data=%h", rd_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_store(input logic [AW-1:0] a, input logic [DW-1:0] d, output logic st);
    sb_entry_t e;
    req_wr = 1'b1; req_addr = a; req_wdata = d;
    #1;
    st = stall;
    e.addr = a; e.data = d;
    wq.push_back(e);
    tick();
    req_wr = 1'b0;
  endtask

  // Completes each write lat (>=2) mem_wr cycles after it is first seen.
  task automatic drain(input int lat);
    int w = 0;
    int n = 0;
    while (wq.size() > 0 && n < 200) begin
      #1;
      if (mem_wr) begin
        if (w == lat - 1) begin mem_done = 1'b1; w = 0; end
        else w++;
      end
      tick();
      mem_done = 1'b0;
      n++;
    end
    cmp_cnt++;
    if (wq.size() != 0) begin mis_cnt++; $display("FAIL drain_timeout: %0d writes left, required 0", wq.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_rd = 1'b0; req_wr = 1'b0; req_addr = 16'hA5A5; req_wdata = '0;
    mem_rdata = '0; mem_done = 1'b0; mem_err = 1'b0;
    tick(); tick();
    cmp_cnt++; if (stall !== 1'b0) begin mis_cnt++; $display("FAIL reset_stall: got %b, required 0", stall); end
    cmp_cnt++; if (rd_valid !== 1'b0) begin mis_cnt++; $display("FAIL reset_rd_valid: got %b, required 0", rd_valid); end
    cmp_cnt++; if (rd_data !== 16'h0) begin mis_cnt++; $display("FAIL reset_rd_data: got %h, required 0000", rd_data); end
    cmp_cnt++; if (err !== 1'b0) begin mis_cnt++; $display("FAIL reset_err: got %b, required 0", err); end
    cmp_cnt++; if ({mem_rd, mem_wr} !== 2'b00) begin mis_cnt++; $display("FAIL reset_mem_rdwr: got %b, required 00", {mem_rd, mem_wr}); end
    cmp_cnt++; if (sb_empty !== 1'b1) begin mis_cnt++; $display("FAIL reset_sb_empty: got %b, required 1", sb_empty); end
    cmp_cnt++; if (addr_out !== 16'hA5A5) begin mis_cnt++; $display("FAIL addr_out: got %h, required a5a5", addr_out); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_store_drain();
    logic st;
    push_store(16'h0010, 16'hBEEF, st);
    cmp_cnt++; if (st !== 1'b0) begin mis_cnt++; $display("FAIL t1_accept: stall got %b, required 0", st); end
    for (int i = 0; i < 3; i++) begin
      mem_done = (i == 2);
      #1;
      cmp_cnt++;
      if ({mem_wr, mem_addr, mem_wdata} !== {1'b1, 16'h0010, 16'hBEEF}) begin
        mis_cnt++;
        $display("FAIL t1_hold%0d: got wr=%b addr=%h data=%h, required wr=1 addr=0010 data=beef", i, mem_wr, mem_addr, mem_wdata);
      end
      tick();
    end
    mem_done = 1'b0;
    #1;
    cmp_cnt++; if ({sb_empty, mem_wr} !== 2'b10) begin mis_cnt++; $display("FAIL t1_empty: got sb_empty=%b mem_wr=%b, required 1 0", sb_empty, mem_wr); end
  endtask

  task automatic test_forward();
    logic st;
    logic [DW-1:0] exp_d;
    push_store(16'h0020, 16'h1111, st);
    cmp_cnt++; if (st !== 1'b0) begin mis_cnt++; $display("FAIL t2_st1: stall got %b, required 0", st); end
    push_store(16'h0020, 16'h2222, st);
    cmp_cnt++; if (st !== 1'b0) begin mis_cnt++; $display("FAIL t2_st2: stall got %b, required 0", st); end
    exp_d = '0;
    foreach (wq[i]) if (wq[i].addr == 16'h0020) exp_d = wq[i].data;
    req_rd = 1'b1; req_addr = 16'h0020;
    #1;
    cmp_cnt++; if (stall !== 1'b0) begin mis_cnt++; $display("FAIL t2_hit_stall: got %b, required 0", stall); end
    rq.push_back(exp_d);
    tick();
    req_rd = 1'b0;
    #1;
    cmp_cnt++; if ({rd_valid, rd_data} !== {1'b1, 16'h2222}) begin mis_cnt++; $display("FAIL t2_youngest: got valid=%b data=%h, required 1 2222", rd_valid, rd_data); end
    drain(2);
  endtask

  task automatic test_load_miss();
    logic st;
    push_store(16'h0050, 16'h5555, st);
    req_rd = 1'b1; req_addr = 16'h0040;
    #1;
    cmp_cnt++;
    if ({mem_rd, mem_wr, mem_addr, stall} !== {1'b1, 1'b0, 16'h0040, 1'b1}) begin
      mis_cnt++;
      $display("FAIL t3_issue: got rd=%b wr=%b addr=%h stall=%b, required 1 0 0040 1", mem_rd, mem_wr, mem_addr, stall);
    end
    cmp_cnt++; if (addr_out !== 16'h0040) begin mis_cnt++; $display("FAIL t3_addr_out: got %h, required 0040", addr_out); end
    tick();
    cmp_cnt++; if ({stall, mem_rd} !== 2'b11) begin mis_cnt++; $display("FAIL t3_wait: got stall=%b rd=%b, required 1 1", stall, mem_rd); end
    tick();
    mem_done = 1'b1; mem_rdata = 16'h1234;
    #1;
    cmp_cnt++; if (stall !== 1'b0) begin mis_cnt++; $display("FAIL t3_release: stall got %b, required 0", stall); end
    rq.push_back(16'h1234);
    tick();
    req_rd = 1'b0; mem_done = 1'b0;
    #1;
    cmp_cnt++; if ({rd_valid, rd_data} !== {1'b1, 16'h1234}) begin mis_cnt++; $display("FAIL t3_result: got valid=%b data=%h, required 1 1234", rd_valid, rd_data); end
    tick();
    cmp_cnt++; if (rd_valid !== 1'b0) begin mis_cnt++; $display("FAIL t3_pulse: rd_valid got %b, required 0", rd_valid); end
    drain(2);
  endtask

  task automatic test_full();
    logic st;
    sb_entry_t e;
    for (int i = 0; i < 4; i++) begin
      push_store(16'h0100 + 16'(i), 16'hA000 + 16'(i), st);
      cmp_cnt++; if (st !== 1'b0) begin mis_cnt++; $display("FAIL t4_fill%0d: stall got %b, required 0", i, st); end
    end
    req_wr = 1'b1; req_addr = 16'h0200; req_wdata = 16'hB5B5;
    #1;
    cmp_cnt++; if (stall !== 1'b1) begin mis_cnt++; $display("FAIL t4_full_a: stall got %b, required 1", stall); end
    tick();
    cmp_cnt++; if (stall !== 1'b1) begin mis_cnt++; $display("FAIL t4_full_b: stall got %b, required 1", stall); end
    mem_done = 1'b1;
    #1;
    cmp_cnt++; if (stall !== 1'b0) begin mis_cnt++; $display("FAIL t4_pushpop: stall got %b, required 0", stall); end
    e.addr = 16'h0200; e.data = 16'hB5B5;
    wq.push_back(e);
    tick();
    mem_done = 1'b0; req_addr = 16'h0201; req_wdata = 16'hC6C6;
    #1;
    cmp_cnt++; if (stall !== 1'b1) begin mis_cnt++; $display("FAIL t4_still_full: stall got %b, required 1", stall); end
    req_wr = 1'b0;
    drain(2);
    cmp_cnt++; if (sb_empty !== 1'b1) begin mis_cnt++; $display("FAIL t4_empty: got %b, required 1", sb_empty); end
  endtask

  task automatic test_reset_mid();
    logic st;
    for (int i = 0; i < 4; i++) push_store(16'h0300 + 16'(i), 16'hD000 + 16'(i), st);
    req_rd = 1'b1; req_addr = 16'h0080; mem_done = 1'b1;
    #1;
    cmp_cnt++; if (stall !== 1'b1) begin mis_cnt++; $display("FAIL t5_miss_in_st: stall got %b, required 1", stall); end
    tick();
    mem_done = 1'b0;
    #1;
    cmp_cnt++; if ({mem_rd, mem_wr} !== 2'b10) begin mis_cnt++; $display("FAIL t5_issue: got rd=%b wr=%b, required 1 0", mem_rd, mem_wr); end
    tick();
    cmp_cnt++; if ({mem_rd, sb_empty} !== 2'b10) begin mis_cnt++; $display("FAIL t5_ldwait: got rd=%b sb_empty=%b, required 1 0", mem_rd, sb_empty); end
    rst = 1'b1; req_rd = 1'b0;
    wq.delete(); rq.delete();
    tick();
    cmp_cnt++; if (mem_rd !== 1'b0) begin mis_cnt++; $display("FAIL t5_mem_rd: got %b, required 0", mem_rd); end
    cmp_cnt++; if (sb_empty !== 1'b1) begin mis_cnt++; $display("FAIL t5_sb_empty: got %b, required 1", sb_empty); end
    cmp_cnt++;
    if ({stall, rd_valid, rd_data, err, mem_wr} !== {1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
      mis_cnt++;
      $display("FAIL t5_outputs: got stall=%b rv=%b rd=%h err=%b wr=%b, required 0 0 0000 0 0", stall, rd_valid, rd_data, err, mem_wr);
    end
    mem_done = 1'b1; mem_rdata = 16'hDEAD;
    tick();
    rst = 1'b0;
    #1;
    cmp_cnt++; if (rd_valid !== 1'b0) begin mis_cnt++; $display("FAIL t5_late_done_a: rd_valid got %b, required 0", rd_valid); end
    tick();
    mem_done = 1'b0;
    #1;
    cmp_cnt++; if ({rd_valid, sb_empty, mem_wr} !== 3'b010) begin mis_cnt++; $display("FAIL t5_late_done_b: got rv=%b empty=%b wr=%b, required 0 1 0", rd_valid, sb_empty, mem_wr); end
  endtask

  task automatic test_err();
    logic st;
    req_rd = 1'b1; req_wr = 1'b1; req_addr = 16'h0090; req_wdata = 16'h9999;
    #1;
    cmp_cnt++; if ({stall, err} !== 2'b00) begin mis_cnt++; $display("FAIL t6_conflict: got stall=%b err=%b, required 0 0", stall, err); end
    tick();
    req_rd = 1'b0; req_wr = 1'b0;
    #1;
    cmp_cnt++; if (err !== 1'b1) begin mis_cnt++; $display("FAIL t6_err_set: got %b, required 1", err); end
    cmp_cnt++; if ({mem_wr, sb_empty} !== 2'b01) begin mis_cnt++; $display("FAIL t6_no_action: got wr=%b empty=%b, required 0 1", mem_wr, sb_empty); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_cnt++; if (err !== 1'b0) begin mis_cnt++; $display("FAIL t6_err_clear1: got %b, required 0", err); end
    mem_err = 1'b1;
    tick();
    mem_err = 1'b0;
    cmp_cnt++; if (err !== 1'b1) begin mis_cnt++; $display("FAIL t6_mem_err: got %b, required 1", err); end
    push_store(16'h0060, 16'h6060, st);
    drain(2);
    cmp_cnt++; if (err !== 1'b1) begin mis_cnt++; $display("FAIL t6_sticky: got %b, required 1", err); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_cnt++; if (err !== 1'b0) begin mis_cnt++; $display("FAIL t6_err_clear2: got %b, required 0", err); end
  endtask

  initial begin
    test_reset();
    test_store_drain();
    test_forward();
    test_load_miss();
    test_full();
    test_reset_mid();
    test_err();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
